// File: rtl/s208_seq_ctrl.sv
// Run sequencer for the s208 counter/compare block: init, P_0 strobing, Z watch.
// Define S208_CTRL_HIT_CNT_EN to run full windows and count every Z hit (hit_cnt port).
module s208_seq_ctrl #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [8:0]       c_cfg,
    input  logic [DIV_W-1:0] p0_div,
    input  logic [CNT_W-1:0] win_len,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic             timeout,
    output logic [CNT_W-1:0] hit_cycle,
    output logic             dut_p0,
    output logic [8:0]       dut_c,
    output logic             dut_setn,
    output logic             dut_rstn,
`ifdef S208_CTRL_HIT_CNT_EN
    output logic [CNT_W-1:0] hit_cnt,
`endif
    input  logic             dut_z
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state, state_n;

    logic [8:0]       c_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_n;
    logic [CNT_W-1:0] win_q;
    logic [CNT_W-1:0] cyc;
    logic             accept;
    logic             last;
    logic             stop;

    logic             busy_d;
    logic             done_d;
    logic             setn_d;
    logic             p0_d;
    logic [8:0]       c_d;

    assign accept = (state == IDLE) && start;
    assign last   = (cyc == win_q - CNT_W'(1));
    assign div_n  = (div == div_q) ? '0 : div + DIV_W'(1);

`ifdef S208_CTRL_HIT_CNT_EN
    assign stop = last;
`else
    assign stop = last || dut_z;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = INIT;
            INIT:    state_n = SETTLE;
            SETTLE:  state_n = (win_q == '0) ? DONE : RUN;
            RUN:     if (stop) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output values for the coming cycle, registered below.
    always_comb begin
        busy_d = (state_n != IDLE);
        done_d = (state_n == DONE);
        setn_d = (state_n != INIT);
        c_d    = '0;
        if (accept) begin
            c_d = c_cfg;
        end else if (state_n != IDLE) begin
            c_d = c_q;
        end
        p0_d = 1'b0;
        if (state_n == RUN) begin
            p0_d = (state == RUN) ? (div_n == '0) : 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            dut_setn <= 1'b0;
            dut_rstn <= 1'b0;
            dut_p0   <= 1'b0;
            dut_c    <= '0;
        end else begin
            busy     <= busy_d;
            done     <= done_d;
            dut_setn <= setn_d;
            dut_rstn <= setn_d;
            dut_p0   <= p0_d;
            dut_c    <= c_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc <= '0;
            div <= '0;
        end else if (state == RUN) begin
            cyc <= cyc + CNT_W'(1);
            div <= div_n;
        end else begin
            cyc <= '0;
            div <= '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_q       <= '0;
            div_q     <= '0;
            win_q     <= '0;
            hit       <= 1'b0;
            timeout   <= 1'b0;
            hit_cycle <= '0;
`ifdef S208_CTRL_HIT_CNT_EN
            hit_cnt   <= '0;
`endif
        end else if (accept) begin
            c_q       <= c_cfg;
            div_q     <= p0_div;
            win_q     <= win_len;
            hit       <= 1'b0;
            timeout   <= 1'b0;
            hit_cycle <= '0;
`ifdef S208_CTRL_HIT_CNT_EN
            hit_cnt   <= '0;
`endif
        end else if (state == SETTLE && win_q == '0) begin
            timeout <= 1'b1;
        end else if (state == RUN) begin
            if (dut_z && !hit) begin
                hit       <= 1'b1;
                hit_cycle <= cyc;
            end
            if (last && !hit && !dut_z) begin
                timeout <= 1'b1;
            end
`ifdef S208_CTRL_HIT_CNT_EN
            if (dut_z && hit_cnt != '1) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
`endif
        end
    end

endmodule
